// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared state encoding, INF constant and edge-word field offsets for the Bellman-Ford engine
package bf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_EDGE_RD,
        S_DIST_RD,
        S_RELAX,
        S_PASS_END,
        S_CHECK,
        S_DONE
    } bf_state_e;

    // Edge word is {src, dst, wgt} with the weight in the low bits.
    localparam int WGT_LSB = 0;

    function automatic int dst_lsb(input int wgt_w);
        return wgt_w;
    endfunction

    function automatic int src_lsb(input int node_w, input int wgt_w);
        return wgt_w + node_w;
    endfunction

    function automatic int edge_w(input int node_w, input int wgt_w);
        return 2 * node_w + wgt_w;
    endfunction

    // Largest positive signed value of a w-bit word, used as "unreached".
    function automatic logic [63:0] inf_val(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/bf_relax_engine_if.sv
// rtl/bf_relax_engine_if.sv - edge-memory and distance-memory bus between the engine and its memories
interface bf_relax_engine_if
    import bf_pkg::*;
#(
    parameter int NODE_W  = 8,
    parameter int EDGE_AW = 13,
    parameter int DIST_W  = 16,
    parameter int WGT_W   = 16
) ();

    logic [EDGE_AW-1:0]                   EMAR;
    logic [edge_w(NODE_W, WGT_W)-1:0]     EMDR;
    logic [NODE_W-1:0]                    DMAR1;
    logic [NODE_W-1:0]                    DMAR2;
    logic [DIST_W-1:0]                    DMDR1;
    logic [DIST_W-1:0]                    DMDR2;
    logic [NODE_W-1:0]                    DMWAR;
    logic [DIST_W-1:0]                    DMWDR;
    logic                                 DMWE;

    modport master (
        output EMAR, DMAR1, DMAR2, DMWAR, DMWDR, DMWE,
        input  EMDR, DMDR1, DMDR2
    );

    modport slave (
        input  EMAR, DMAR1, DMAR2, DMWAR, DMWDR, DMWE,
        output EMDR, DMDR1, DMDR2
    );

endinterface

// File: rtl/bf_relax_alu.sv
// rtl/bf_relax_alu.sv - saturating candidate distance and improvement test for one edge
module bf_relax_alu
    import bf_pkg::*;
#(
    parameter int DIST_W = 16,
    parameter int WGT_W  = 16
) (
    input  logic [DIST_W-1:0] d_src_i,
    input  logic [DIST_W-1:0] d_dst_i,
    input  logic [WGT_W-1:0]  wgt_i,
    output logic [DIST_W-1:0] cand_o,
    output logic              improve_o
);

    localparam logic [DIST_W-1:0] INF = DIST_W'(inf_val(DIST_W));
    // Upper clamp is INF-1 so a real path length can never look unreached.
    localparam logic signed [DIST_W:0] HI = {2'b00, {(DIST_W-2){1'b1}}, 1'b0};
    localparam logic signed [DIST_W:0] LO = {2'b11, {(DIST_W-1){1'b0}}};

    logic signed [DIST_W:0] sum;

    assign sum = $signed({d_src_i[DIST_W-1], d_src_i})
               + $signed({{(DIST_W+1-WGT_W){wgt_i[WGT_W-1]}}, wgt_i});

    always_comb begin
        cand_o = sum[DIST_W-1:0];
        if (sum > HI) begin
            cand_o = HI[DIST_W-1:0];
        end else if (sum < LO) begin
            cand_o = LO[DIST_W-1:0];
        end
    end

    assign improve_o = (d_src_i != INF) && ($signed(cand_o) < $signed(d_dst_i));

endmodule

// File: rtl/bf_relax_engine.sv
// rtl/bf_relax_engine.sv - sequential Bellman-Ford relaxation engine; NEGCYC_DETECT_EN adds a negative-cycle check pass
module bf_relax_engine
    import bf_pkg::*;
#(
    parameter int NODE_W  = 8,
    parameter int EDGE_AW = 13,
    parameter int DIST_W  = 16,
    parameter int WGT_W   = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NODE_W-1:0]           num_nodes,
    input  logic [EDGE_AW-1:0]          num_edges,
    input  logic [NODE_W-1:0]           source,
    output logic [EDGE_AW-1:0]          EMAR,
    input  logic [2*NODE_W+WGT_W-1:0]   EMDR,
    output logic [NODE_W-1:0]           DMAR1,
    output logic [NODE_W-1:0]           DMAR2,
    input  logic [DIST_W-1:0]           DMDR1,
    input  logic [DIST_W-1:0]           DMDR2,
    output logic [NODE_W-1:0]           DMWAR,
    output logic [DIST_W-1:0]           DMWDR,
    output logic                        DMWE,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        neg_cycle,
    output logic [NODE_W-1:0]           pass_count
);

    localparam logic [DIST_W-1:0] INF     = DIST_W'(inf_val(DIST_W));
    localparam int                SRC_LSB = src_lsb(NODE_W, WGT_W);
    localparam int                DST_LSB = dst_lsb(WGT_W);

    bf_state_e          state_q;
    logic [EDGE_AW-1:0] e_q, ne_q;
    logic [NODE_W-1:0]  n_q, num_q, srcn_q, dst_q, pass_q;
    logic [WGT_W-1:0]   wgt_q;
    logic               changed_q, busy_q, done_q, err_q;
    logic               check_w;
    logic [DIST_W-1:0]  cand;
    logic               improve;
    logic [NODE_W-1:0]  pass_next;

    bf_relax_alu #(.DIST_W(DIST_W), .WGT_W(WGT_W)) u_alu (
        .d_src_i   (DMDR1),
        .d_dst_i   (DMDR2),
        .wgt_i     (wgt_q),
        .cand_o    (cand),
        .improve_o (improve)
    );

`ifdef NEGCYC_DETECT_EN
    logic check_q, neg_q;
    assign check_w   = check_q;
    assign neg_cycle = neg_q;
`else
    assign check_w   = 1'b0;
    assign neg_cycle = 1'b0;
`endif

    assign pass_next = pass_q + NODE_W'(1);

    // Memory strobes are decoded from the registered state so reads and writes land in the state that owns them.
    assign EMAR  = (state_q == S_EDGE_RD) ? e_q : '0;
    assign DMAR1 = (state_q == S_DIST_RD) ? EMDR[SRC_LSB +: NODE_W] : '0;
    assign DMAR2 = (state_q == S_DIST_RD) ? EMDR[DST_LSB +: NODE_W] : '0;
    assign DMWE  = (state_q == S_INIT) || ((state_q == S_RELAX) && improve && !check_w);
    assign DMWAR = (state_q == S_INIT) ? n_q : ((state_q == S_RELAX) ? dst_q : '0);
    assign DMWDR = (state_q == S_INIT)  ? ((n_q == srcn_q) ? '0 : INF)
                 : (state_q == S_RELAX) ? cand : '0;

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign pass_count = pass_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            e_q       <= '0;
            ne_q      <= '0;
            n_q       <= '0;
            num_q     <= '0;
            srcn_q    <= '0;
            dst_q     <= '0;
            wgt_q     <= '0;
            pass_q    <= '0;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef NEGCYC_DETECT_EN
            check_q   <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_q     <= num_nodes;
                        ne_q      <= num_edges;
                        srcn_q    <= source;
                        pass_q    <= '0;
                        err_q     <= 1'b0;
                        changed_q <= 1'b0;
                        n_q       <= '0;
                        e_q       <= '0;
                        busy_q    <= 1'b1;
`ifdef NEGCYC_DETECT_EN
                        check_q   <= 1'b0;
                        neg_q     <= 1'b0;
`endif
                        if (num_nodes == '0 || source >= num_nodes) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_INIT;
                        end
                    end
                end
                S_INIT: begin
                    n_q <= n_q + NODE_W'(1);
                    if (n_q == num_q - NODE_W'(1)) begin
                        if (num_q == NODE_W'(1)) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (ne_q == '0) begin
                            state_q <= S_PASS_END;
                        end else begin
                            state_q <= S_EDGE_RD;
                        end
                    end
                end
                S_EDGE_RD: state_q <= S_DIST_RD;
                S_DIST_RD: begin
                    dst_q   <= EMDR[DST_LSB +: NODE_W];
                    wgt_q   <= EMDR[WGT_LSB +: WGT_W];
                    state_q <= S_RELAX;
                end
                S_RELAX: begin
`ifdef NEGCYC_DETECT_EN
                    if (improve && check_q) neg_q <= 1'b1;
`endif
                    if (improve && !check_w) changed_q <= 1'b1;
                    if (e_q == ne_q - EDGE_AW'(1)) begin
                        state_q <= S_PASS_END;
                    end else begin
                        e_q     <= e_q + EDGE_AW'(1);
                        state_q <= S_EDGE_RD;
                    end
                end
                S_PASS_END: begin
                    e_q       <= '0;
                    changed_q <= 1'b0;
`ifdef NEGCYC_DETECT_EN
                    if (check_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else
`endif
                    begin
                        pass_q <= pass_next;
                        if (!changed_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else if (pass_next == num_q - NODE_W'(1)) begin
`ifdef NEGCYC_DETECT_EN
                            state_q <= S_CHECK;
`else
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
`endif
                        end else begin
                            state_q <= S_EDGE_RD;
                        end
                    end
                end
`ifdef NEGCYC_DETECT_EN
                S_CHECK: begin
                    check_q <= 1'b1;
                    e_q     <= '0;
                    state_q <= S_EDGE_RD;
                end
`endif
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bf_relax_engine.md
BF_RELAX_ENGINE -- requirements
Module: bf_relax_engine

Interface
REQ-001 SHALL have parameter NODE_W, default 8, node-index width.
REQ-002 SHALL have parameter EDGE_AW, default 13, edge-memory address width.
REQ-003 SHALL have parameter DIST_W, default 16, signed distance width.
REQ-004 SHALL have parameter WGT_W, default 16, signed edge-weight width (WGT_W <= DIST_W).
REQ-005 SHALL have ports, in this order:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle run request.
- num_nodes  in  NODE_W  node count N.
- num_edges  in  EDGE_AW  edge count E.
- source  in  NODE_W  source node.
- EMAR  out  EDGE_AW  edge-memory read address.
- EMDR  in  2*NODE_W+WGT_W  edge word {src,dst,wgt}, valid 1 cycle after EMAR.
- DMAR1/DMAR2  out  NODE_W  distance-memory read addresses.
- DMDR1/DMDR2  in  DIST_W  read data, 1-cycle latency.
- DMWAR  out  NODE_W  distance write address.
- DMWDR  out  DIST_W  distance write data.
- DMWE  out  1  distance write enable.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  invalid configuration.
- neg_cycle  out  1  negative cycle found.
- pass_count  out  NODE_W  relaxation passes executed.

Function
REQ-006 SHALL sample num_nodes, num_edges and source on start in IDLE; start SHALL be ignored while busy.
REQ-007 SHALL implement states IDLE -> INIT -> EDGE_RD -> DIST_RD -> RELAX (repeating per edge) -> PASS_END -> [CHECK] -> DONE -> IDLE.
REQ-008 INIT SHALL write INF (max positive, 0111..1) to nodes 0..N-1, one per cycle, writing 0 to source instead; duration N cycles.
REQ-009 EDGE_RD SHALL drive EMAR=e; DIST_RD SHALL drive DMAR1=src, DMAR2=dst from EMDR; RELAX SHALL evaluate the edge: 3 cycles per edge, no pipelining.
REQ-010 RELAX SHALL compute cand=DMDR1+sign-extended wgt in DIST_W+1 bits, saturate to the DIST_W signed range, and never produce INF.
REQ-011 RELAX SHALL assert DMWE for one cycle with DMWAR=dst, DMWDR=cand only when DMDR1!=INF and cand<DMDR2 (signed); on write it SHALL set the pass-changed flag.
REQ-012 PASS_END SHALL increment pass_count, then go to DONE if the pass made no change or pass_count==N-1, else clear the flag and restart at edge 0.
REQ-013 N<=1 SHALL skip the passes (pass_count=0); E==0 SHALL yield one pass with no change.
REQ-014 source>=N or N==0 SHALL set err, perform no memory writes, and go directly to DONE.
REQ-015 done SHALL pulse for exactly one cycle; busy SHALL be high from the cycle after start through DONE; err, neg_cycle and pass_count SHALL hold until the next accepted start, which clears them.
REQ-016 DMWE SHALL never be asserted outside INIT and RELAX.

Reset
REQ-017 reset SHALL force IDLE and all outputs to 0 (addresses, DMWDR, DMWE, busy, done, err, neg_cycle, pass_count), including mid-run; distance-memory contents SHALL be left as-is.

Configuration
REQ-018 With NEGCYC_DETECT_EN defined:
- after N-1 passes ending with a change, CHECK SHALL run one further full edge pass with DMWE held low;
- neg_cycle SHALL be set if any edge satisfies the REQ-011 condition.
Without NEGCYC_DETECT_EN, CHECK SHALL be absent and neg_cycle SHALL be tied 0.

Structure
REQ-019 A shared package bf_pkg SHALL hold the state enum, the INF constant function, and edge-field offset constants.
REQ-020 The saturating add-and-compare SHALL be a sub-module, bf_relax_alu (combinational), instantiated once.

Verification
REQ-021 N=4, edges 0->1 w5, 1->2 w-2, 2->3 w4, source 0 -> distances {0,5,3,7}, pass_count=2, done pulse, neg_cycle=0.
REQ-022 N=3, edge 0->1 w1, source 0 -> node 2 stays 0x7FFF, pass_count=2.
REQ-023 With NEGCYC_DETECT_EN: N=2, edges 0->1 w1, 1->0 w-3 -> neg_cycle=1 and no DMWE during CHECK; without the macro -> neg_cycle=0, pass_count=1.
REQ-024 source=5, N=4 -> err=1, zero DMWE cycles, done in <=3 cycles.
REQ-025 Reset asserted mid-INIT -> next cycle busy=0, DMWE=0; a new start completes normally.
REQ-026 Saturation: dist[src]=-32760, w=-100 -> dst written -32768.
